// File: rtl/instr_fetch.sv
// Instruction-fetch stage: holds the PC, runs the req/ack handshake with
// instruction memory and presents the fetched word. Option: FETCH_STALL_CNT_EN.
module instr_fetch #(
    parameter int unsigned          ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ack,
    input  logic              consume,
    input  logic              branch,
    input  logic              alu_zero,
    input  logic [31:0]       branch_offset,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic [5:0]        opcode,
    output logic [ADDR_W-1:0] pc,
`ifdef FETCH_STALL_CNT_EN
    output logic [31:0]       stall_cnt,
`endif
    output logic [ADDR_W-1:0] pc_plus4
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_e;

    state_e            state_q;
    logic              req_q;
    logic              valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       instr_q;

    logic [ADDR_W-1:0] pc4_d;
    logic [ADDR_W-1:0] off_d;
    logic [ADDR_W-1:0] next_pc_d;

    // Offset is in words; shift to bytes, wrap silently at ADDR_W.
    assign pc4_d     = pc_q + ADDR_W'(4);
    assign off_d     = ADDR_W'({branch_offset, 2'b00});
    assign next_pc_d = (branch && alu_zero) ? (pc4_d + off_d) : pc4_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            addr_q  <= RESET_PC;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    req_q   <= 1'b1;
                    addr_q  <= pc_q;
                    state_q <= FETCH;
                end
                FETCH: begin
                    if (imem_ack) begin
                        instr_q <= imem_rdata;
                        valid_q <= 1'b1;
                        req_q   <= 1'b0;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (consume) begin
                        valid_q <= 1'b0;
                        pc_q    <= next_pc_d;
                        addr_q  <= next_pc_d;
                        req_q   <= 1'b1;
                        state_q <= FETCH;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (state_q == FETCH && !imem_ack && stall_q != 32'hFFFF_FFFF) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign pc          = pc_q;
    assign pc_plus4    = pc4_d;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, zero-wait and stalled fetches,
// branch targets, PC wrap-around and reset with a request outstanding.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        consume;
    logic        branch;
    logic        alu_zero;
    logic [31:0] branch_offset;

    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] pc;
    logic [31:0] pc4;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [5:0]  w_opcode;
    logic [31:0] w_pc;
    logic [31:0] w_pc4;

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] w_stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instr_fetch u_dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (req),
        .imem_addr    (addr),
        .imem_rdata   (imem_rdata),
        .imem_ack     (imem_ack),
        .consume      (consume),
        .branch       (branch),
        .alu_zero     (alu_zero),
        .branch_offset(branch_offset),
        .instr_valid  (valid),
        .instr        (instr),
        .opcode       (opcode),
        .pc           (pc),
`ifdef FETCH_STALL_CNT_EN
        .stall_cnt    (stall_cnt),
`endif
        .pc_plus4     (pc4)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (w_req),
        .imem_addr    (w_addr),
        .imem_rdata   (imem_rdata),
        .imem_ack     (imem_ack),
        .consume      (consume),
        .branch       (branch),
        .alu_zero     (alu_zero),
        .branch_offset(branch_offset),
        .instr_valid  (w_valid),
        .instr        (w_instr),
        .opcode       (w_opcode),
        .pc           (w_pc),
`ifdef FETCH_STALL_CNT_EN
        .stall_cnt    (w_stall_cnt),
`endif
        .pc_plus4     (w_pc4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Ack in the current cycle, then present the word.
    task automatic do_fetch(input logic [31:0] word);
        imem_ack   = 1'b1;
        imem_rdata = word;
        step();
        imem_ack   = 1'b0;
    endtask

    task automatic do_consume(input logic b, input logic z,
                              input logic [31:0] off);
        consume       = 1'b1;
        branch        = b;
        alu_zero      = z;
        branch_offset = off;
        step();
        consume       = 1'b0;
        branch        = 1'b0;
        alu_zero      = 1'b0;
        branch_offset = '0;
    endtask

    initial begin
        rst           = 1'b1;
        imem_ack      = 1'b0;
        imem_rdata    = '0;
        consume       = 1'b0;
        branch        = 1'b0;
        alu_zero      = 1'b0;
        branch_offset = '0;

        step();
        step();
        chk("rst_req", {31'd0, req}, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_opcode", {26'd0, opcode}, 32'd0);
        chk("rst_wpc", w_pc, 32'hFFFF_FFFC);

        rst = 1'b0;
        chk("idle_req", {31'd0, req}, 32'd0);
        step();
        chk("fetch_req", {31'd0, req}, 32'd1);
        chk("fetch_addr", addr, 32'd0);

        do_fetch(32'h8C08_0004);
        chk("zw_valid", {31'd0, valid}, 32'd1);
        chk("zw_opcode", {26'd0, opcode}, 32'd35);
        chk("zw_pc", pc, 32'd0);
        chk("zw_pc4", pc4, 32'd4);
        chk("zw_req", {31'd0, req}, 32'd0);
        chk("wrap_pc4", w_pc4, 32'd0);

        do_consume(1'b0, 1'b0, 32'd0);
        chk("seq_req", {31'd0, req}, 32'd1);
        chk("seq_addr", addr, 32'd4);
        chk("seq_valid", {31'd0, valid}, 32'd0);
        chk("wrap_addr", w_addr, 32'd0);
        chk("wrap_pc", w_pc, 32'd0);

        // Three stalled cycles; consume here must have no effect.
        consume = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("ws_req", {31'd0, req}, 32'd1);
            chk("ws_addr", addr, 32'd4);
            chk("ws_valid", {31'd0, valid}, 32'd0);
            step();
        end
        consume = 1'b0;
        chk("ws_req_end", {31'd0, req}, 32'd1);
        chk("ws_addr_end", addr, 32'd4);
`ifdef FETCH_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, 32'd3);
`endif
        do_fetch(32'h1234_5678);
        chk("ws_valid_rise", {31'd0, valid}, 32'd1);
        chk("ws_instr", instr, 32'h1234_5678);
        chk("ws_pc", pc, 32'd4);
`ifdef FETCH_STALL_CNT_EN
        chk("stall_hold", stall_cnt, 32'd3);
`endif

        do_consume(1'b0, 1'b0, 32'd0);
        do_fetch(32'h0000_0008);
        do_consume(1'b0, 1'b0, 32'd0);
        do_fetch(32'h0000_000C);
        do_consume(1'b0, 1'b0, 32'd0);
        chk("to10_addr", addr, 32'h10);
        do_fetch(32'h1000_FFFE);
        chk("at10_pc", pc, 32'h10);

        // Branch inputs without consume must not disturb anything.
        branch   = 1'b1;
        alu_zero = 1'b1;
        for (int i = 0; i < 5; i++) step();
        branch   = 1'b0;
        alu_zero = 1'b0;
        chk("hold_pc", pc, 32'h10);
        chk("hold_instr", instr, 32'h1000_FFFE);
        chk("hold_valid", {31'd0, valid}, 32'd1);
        chk("hold_req", {31'd0, req}, 32'd0);

        do_consume(1'b1, 1'b1, 32'hFFFF_FFFE);
        chk("br_taken", addr, 32'h0C);
        do_fetch(32'hAAAA_0000);
        chk("br_pc", pc, 32'h0C);
        do_consume(1'b0, 1'b0, 32'd0);
        do_fetch(32'hBBBB_0000);
        chk("back10_pc", pc, 32'h10);
        do_consume(1'b1, 1'b0, 32'hFFFF_FFFE);
        chk("br_not_taken", addr, 32'h14);
        chk("bnt_req", {31'd0, req}, 32'd1);

        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_req", {31'd0, req}, 32'd0);
        chk("mid_rst_addr", addr, 32'd0);
        chk("mid_rst_pc", pc, 32'd0);
        chk("mid_rst_valid", {31'd0, valid}, 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        step();
        imem_ack   = 1'b0;
        chk("late_ack_valid", {31'd0, valid}, 32'd0);
        chk("late_ack_instr", instr, 32'd0);
        chk("fresh_req", {31'd0, req}, 32'd1);
        chk("fresh_addr", addr, 32'd0);
`ifdef FETCH_STALL_CNT_EN
        chk("stall_rst", stall_cnt, 32'd0);
`endif
        step();
        chk("fresh_valid", {31'd0, valid}, 32'd0);
        chk("fresh_hold", {31'd0, req}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction-fetch stage directly upstream of the main control decoder.
- Holds the PC and runs a req/ack handshake with instruction memory.
- Latches the fetched word and presents it, with its opcode field, to the control and datapath.
- Computes the next PC (sequential or beq target) when the core consumes the instruction.

Parameters:
- ADDR_W, 32, width of PC and instruction-memory address.
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  ADDR_W  byte address of the word requested.
- imem_rdata  in  32  instruction word; valid only when imem_ack=1.
- imem_ack  in  1  memory returns imem_rdata this cycle.
- consume  in  1  core has executed the presented instruction this cycle.
- branch  in  1  branch control bit from the decoder.
- alu_zero  in  1  ALU zero flag for the presented instruction.
- branch_offset  in  32  sign-extended immediate, in words.
- instr_valid  out  1  instr/opcode/pc hold a fetched instruction.
- instr  out  32  latched instruction word.
- opcode  out  6  instr[31:26], feeds the control decoder.
- pc  out  ADDR_W  address of the presented instruction.
- pc_plus4  out  ADDR_W  pc+4, mod 2^ADDR_W.

Behaviour:
- Reset values, forced while rst=1: state=IDLE, imem_req=0, imem_addr=RESET_PC, pc=RESET_PC, instr=0, instr_valid=0. opcode is therefore 0; consumers must gate on instr_valid.
- States:
  - IDLE: imem_req=0. Unconditionally goes to FETCH next cycle. imem_ack is ignored here.
  - FETCH: imem_req=1, imem_addr=pc; both held stable until ack. On imem_ack=1, latch instr<=imem_rdata, set instr_valid<=1, go to ISSUE.
  - ISSUE: imem_req=0, instr_valid=1. Holds until consume=1. On consume, set instr_valid<=0, load pc<=next_pc and imem_addr<=next_pc, go to FETCH.
- next_pc, sampled only on the consume cycle in ISSUE:
  - branch&alu_zero: pc+4+(branch_offset<<2).
  - otherwise: pc+4.
  - All arithmetic truncated to ADDR_W bits; wrap-around is legal and silent.
  - pc[1:0] is always 00.
- consume outside ISSUE is ignored. branch/alu_zero/branch_offset are don't-care outside the consume cycle.
- imem_ack in the same cycle imem_req first rises is legal (zero wait state).
- Minimum throughput: 2 cycles per instruction.
- Latency: instr_valid rises the cycle after ack.
- Reset mid-operation (any state, including FETCH with request outstanding): next cycle is IDLE with reset values. Memory contract: deasserting imem_req abandons the outstanding request; a late ack is ignored in IDLE.
- No X propagation: all state registers are reset.

Optional Feature:
- Macro: FETCH_STALL_CNT_EN
- With the macro defined:
  - Extra output stall_cnt, out, 32.
  - Counts cycles in FETCH with imem_ack=0.
  - Reset to 0; saturates at 32'hFFFF_FFFF; never clears except by rst.
- Without it: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset: rst=1 for 2 cycles, then 0 -> during reset imem_req=0, pc=0, instr_valid=0. First cycle after release: IDLE, req=0. Next cycle: imem_req=1, imem_addr=0.
- Zero-wait fetch: ack with rdata=32'h8C08_0004 in the first FETCH cycle -> next cycle instr_valid=1, opcode=35, pc=0, pc_plus4=4. consume=1 -> next cycle imem_req=1, imem_addr=4.
- Wait states: ack 3 cycles after req -> imem_addr and req stable for all 3 cycles, instr_valid=0 throughout. With the macro, stall_cnt=3.
- Branch: pc=32'h10, consume with branch=1, alu_zero=1, offset=32'hFFFF_FFFE -> imem_addr=32'h0C. Repeat with alu_zero=0 -> 32'h14. Holding consume=0 for 5 cycles keeps instr/pc unchanged.
- Wrap: RESET_PC=32'hFFFF_FFFC, consume without branch -> next imem_addr=32'h0, pc_plus4 was 0.
- Reset during wait: rst pulsed while req pending, then ack the cycle after -> ack ignored. instr_valid stays 0. Fresh request issued to RESET_PC one cycle later.
